// File: rtl/sc_mmio_ctrl.sv
// rtl/sc_mmio_ctrl.sv - MMIO switch/seven-segment/timer controller with debounce and BCD display
module sc_mmio_ctrl #(
   parameter int NUM_IN    = 2,
   parameter int IN_W      = 5,
   parameter int NUM_DIG   = 6,
   parameter int DB_CYCLES = 16
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    sel,
   input  logic [7:0]              addr,
   input  logic                    we,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   input  logic [NUM_IN*IN_W-1:0]  in_port,
   output logic [NUM_DIG*7-1:0]    dt,
   output logic                    irq
);

   // word offsets (addr[7:2]) of the register window
   localparam logic [5:0]  A_DISP   = 6'h10;
   localparam logic [5:0]  A_CTRL   = 6'h11;
   localparam logic [5:0]  A_TIMER  = 6'h12;
   localparam logic [5:0]  A_CMP    = 6'h13;
   localparam logic [5:0]  A_STATUS = 6'h14;
   localparam logic [15:0] DB_LAST  = 16'(DB_CYCLES - 1);
   localparam int          DW       = NUM_DIG * 4;

   logic [5:0]             off;
   logic                   wr;
   logic                   w1c;
   logic                   unused_addr;

   logic [31:0]            disp_q, disp_d;
   logic [2:0]             ctrl_q, ctrl_d;
   logic [31:0]            timer_q, timer_d;
   logic [31:0]            cmp_q, cmp_d;
   logic                   match_q, match_d;
   logic                   chg_q, chg_d;
   logic                   irq_q, irq_d;
   logic                   match_set;
   logic                   chg_set;

   logic [NUM_IN*IN_W-1:0] sync1_q, sync1_d;
   logic [NUM_IN*IN_W-1:0] sync2_q, sync2_d;
   logic [NUM_IN*IN_W-1:0] stable_q, stable_d;
   logic [15:0]            db_cnt_q [NUM_IN];
   logic [15:0]            db_cnt_d [NUM_IN];

   logic [31:0]            bin_q, bin_d;
   logic [DW-1:0]          bcd_q, bcd_d;
   logic [4:0]             cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic [DW-1:0]          shown_q, shown_d;
   logic [DW-1:0]          bcd_adj;
   logic [DW-1:0]          bcd_shift;

   logic [31:0]            rdata_v;
   logic [NUM_DIG*7-1:0]   dt_v;

   assign off         = addr[7:2];
   assign unused_addr = ^addr[1:0];
   assign wr          = sel & we;
   assign w1c         = wr && (off == A_STATUS);

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   // CPU writes to the plain read/write registers
   always_comb begin
      disp_d = disp_q;
      ctrl_d = ctrl_q;
      cmp_d  = cmp_q;
      if (wr) begin
         case (off)
            A_DISP:  disp_d = wdata;
            A_CTRL:  ctrl_d = wdata[2:0];
            A_CMP:   cmp_d  = wdata;
            default: ;
         endcase
      end
   end

   // timer, sticky flags (hardware set beats W1C) and registered interrupt
   always_comb begin
      timer_d   = timer_q;
      match_set = 1'b0;
      if (wr && (off == A_TIMER)) begin
         timer_d = '0;
      end else if (ctrl_q[1]) begin
         if (timer_q == cmp_q) begin
            timer_d   = '0;
            match_set = 1'b1;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end
      match_d = match_set | (match_q & ~(w1c & wdata[0]));
      chg_d   = chg_set | (chg_q & ~(w1c & wdata[1]));
      irq_d   = ctrl_q[2] & (match_q | chg_q);
   end

   // two-flop synchronisers and per-port debounce counters
   always_comb begin
      sync1_d  = in_port;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      chg_set  = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i*IN_W +: IN_W] == stable_q[i*IN_W +: IN_W]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            stable_d[i*IN_W +: IN_W] = sync2_q[i*IN_W +: IN_W];
            db_cnt_d[i]              = '0;
            chg_set                  = 1'b1;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 16'd1;
         end
      end
   end

   // shift-add-3 conversion; the shown digits only change in hex mode or when a conversion ends
   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      shown_d = shown_q;
      bcd_adj = bcd_q;
      for (int k = 0; k < NUM_DIG; k++) begin
         if (bcd_q[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
      end
      bcd_shift = {bcd_adj[DW-2:0], bin_q[31]};
      if (!ctrl_d[0]) begin
         busy_d  = 1'b0;
         shown_d = disp_d[DW-1:0];
      end else if (wr && ((off == A_DISP) || (off == A_CTRL))) begin
         bin_d  = disp_d;
         bcd_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         bin_d = {bin_q[30:0], 1'b0};
         bcd_d = bcd_shift;
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            busy_d  = 1'b0;
            shown_d = bcd_shift;
         end
      end
   end

   // read mux, zero outside the window or at unmapped offsets
   always_comb begin
      rdata_v = '0;
      if (sel) begin
         case (off)
            A_DISP:   rdata_v = disp_q;
            A_CTRL:   rdata_v = {29'd0, ctrl_q};
            A_TIMER:  rdata_v = timer_q;
            A_CMP:    rdata_v = cmp_q;
            A_STATUS: rdata_v = {29'd0, busy_q, chg_q, match_q};
            default: begin
               for (int i = 0; i < NUM_IN; i++) begin
                  if (off == 6'(i)) rdata_v = 32'(stable_q[i*IN_W +: IN_W]);
               end
            end
         endcase
      end
   end

   // segment decode of the held digit nibbles
   always_comb begin
      dt_v = '0;
      for (int k = 0; k < NUM_DIG; k++) dt_v[k*7 +: 7] = seg7(shown_q[k*4 +: 4]);
   end

   assign rdata = rdata_v;
   assign dt    = dt_v;
   assign irq   = irq_q;

   // state registers, all cleared by the asynchronous reset
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         disp_q   <= '0;
         ctrl_q   <= '0;
         timer_q  <= '0;
         cmp_q    <= '0;
         match_q  <= 1'b0;
         chg_q    <= 1'b0;
         irq_q    <= 1'b0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < NUM_IN; i++) db_cnt_q[i] <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         shown_q  <= '0;
      end else begin
         disp_q   <= disp_d;
         ctrl_q   <= ctrl_d;
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         match_q  <= match_d;
         chg_q    <= chg_d;
         irq_q    <= irq_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         for (int i = 0; i < NUM_IN; i++) db_cnt_q[i] <= db_cnt_d[i];
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         shown_q  <= shown_d;
      end
   end

endmodule

// File: tb/tb_sc_mmio_ctrl.sv
// tb/tb_sc_mmio_ctrl.sv - directed self-checking bench for sc_mmio_ctrl
module tb_sc_mmio_ctrl;

   logic        clock;
   logic        resetn;
   logic        sel;
   logic [7:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [9:0]  in_port;
   logic [41:0] dt;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [41:0] dt_zero;
   logic [41:0] dt_hex1;
   logic [41:0] dt_dec;
   logic [41:0] dt_hex2;
   logic [31:0] rd;

   sc_mmio_ctrl #(
      .NUM_IN(2), .IN_W(5), .NUM_DIG(6), .DB_CYCLES(4)
   ) dut (
      .clock(clock), .resetn(resetn), .sel(sel), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata), .in_port(in_port), .dt(dt), .irq(irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   // write is presented at a negedge, committed on the next posedge, returns at the following negedge
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clock);
      sel = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
      sel = 1'b1; we = 1'b0; addr = a;
      #1;
      d = rdata;
      sel = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd_reg(a, v);
      chk(tag, 64'(v), 64'(exp));
   endtask

   initial begin
      dt_zero = {6{7'h40}};
      dt_hex1 = {7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h0E};
      dt_dec  = {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
      dt_hex2 = {7'h79, 7'h24, 7'h21, 7'h02, 7'h00, 7'h78};

      resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; in_port = '0;
      cyc(3);
      chk("reset_dt", 64'(dt), 64'(dt_zero));
      chk("reset_irq", 64'(irq), 64'd0);
      chk_reg("reset_in0", 8'h00, 32'h0);
      resetn = 1'b1;
      cyc(2);
      chk_reg("status_idle", 8'h50, 32'h0);

      // debounce: value appears on the 6th edge after it is applied
      in_port[4:0] = 5'h15;
      cyc(5);
      chk_reg("db_early", 8'h00, 32'h0);
      cyc(1);
      chk_reg("db_in0", 8'h00, 32'h15);
      chk_reg("db_status", 8'h50, 32'h2);
      chk_reg("db_in1", 8'h04, 32'h0);
      chk_reg("unmapped", 8'h08, 32'h0);
      wr(8'h50, 32'h2);
      chk_reg("db_w1c", 8'h50, 32'h0);
      in_port[4:0] = 5'h00;
      cyc(3);
      in_port[4:0] = 5'h15;
      cyc(10);
      chk_reg("glitch_in0", 8'h00, 32'h15);
      chk_reg("glitch_status", 8'h50, 32'h0);

      // hex display
      wr(8'h40, 32'h00123ABF);
      chk("hex_dt", 64'(dt), 64'(dt_hex1));
      chk_reg("disp_rd", 8'h40, 32'h00123ABF);
      wr(8'h48 | 8'h01, 32'h0);

      // decimal conversion, restarted by the DISP write one cycle after CTRL
      wr(8'h44, 32'h1);
      wr(8'h40, 32'd1234567);
      for (int i = 0; i < 32; i++) begin
         chk_reg("dec_busy", 8'h50, 32'h4);
         chk("dec_hold", 64'(dt), 64'(dt_hex1));
         cyc(1);
      end
      chk_reg("dec_done", 8'h50, 32'h0);
      chk("dec_dt", 64'(dt), 64'(dt_dec));

      // back to hex, then abort a conversion by leaving decimal mode
      wr(8'h44, 32'h0);
      chk("hex2_dt", 64'(dt), 64'(dt_hex2));
      wr(8'h44, 32'h1);
      cyc(3);
      chk_reg("abort_busy", 8'h50, 32'h4);
      wr(8'h44, 32'h0);
      chk_reg("abort_clear", 8'h50, 32'h0);
      cyc(40);
      chk("abort_dt", 64'(dt), 64'(dt_hex2));

      // timer match, interrupt and W1C
      wr(8'h4C, 32'd5);
      wr(8'h48, 32'h0);
      wr(8'h44, 32'h6);
      cyc(5);
      chk_reg("tmr_at5", 8'h48, 32'd5);
      chk_reg("tmr_noflag", 8'h50, 32'h0);
      cyc(1);
      chk_reg("tmr_flag", 8'h50, 32'h1);
      chk_reg("tmr_wrap", 8'h48, 32'd0);
      chk("tmr_irq_lag", 64'(irq), 64'd0);
      cyc(1);
      chk("tmr_irq", 64'(irq), 64'd1);
      chk_reg("tmr_after", 8'h48, 32'd1);
      wr(8'h50, 32'h1);
      chk_reg("tmr_w1c", 8'h50, 32'h0);
      cyc(1);
      chk("tmr_irq_clr", 64'(irq), 64'd0);

      // TIMER write on the match edge wins, no flag
      wr(8'h48, 32'h0);
      cyc(5);
      chk_reg("sim_at5", 8'h48, 32'd5);
      wr(8'h48, 32'h0);
      chk_reg("sim_twr_tmr", 8'h48, 32'd0);
      chk_reg("sim_twr_flag", 8'h50, 32'h0);

      // W1C coincident with a match: set wins
      cyc(5);
      chk_reg("sim2_at5", 8'h48, 32'd5);
      wr(8'h50, 32'h1);
      chk_reg("sim_w1c_flag", 8'h50, 32'h1);
      chk_reg("sim_w1c_tmr", 8'h48, 32'd0);

      // timer hold when disabled
      wr(8'h44, 32'h0);
      cyc(3);
      chk_reg("tmr_hold", 8'h48, 32'd1);
      chk("irq_disabled", 64'(irq), 64'd0);

      // reset in the middle of a conversion
      wr(8'h44, 32'h1);
      wr(8'h40, 32'd1000000);
      cyc(5);
      in_port = '0;
      resetn = 1'b0;
      #1;
      chk("rst_mid_dt", 64'(dt), 64'(dt_zero));
      chk_reg("rst_mid_status", 8'h50, 32'h0);
      chk("rst_mid_irq", 64'(irq), 64'd0);
      cyc(2);
      resetn = 1'b1;
      cyc(40);
      chk("rst_after_dt", 64'(dt), 64'(dt_zero));
      chk_reg("rst_after_status", 8'h50, 32'h0);
      chk_reg("rst_after_disp", 8'h40, 32'h0);
      chk_reg("rst_after_ctrl", 8'h44, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
